// File: rtl/lab3_cache_mem_pkg.sv
// Shared types and constants for the cache <-> memory 16-beat line-transfer protocol.
package lab3_cache_mem_pkg;

  localparam int CACHE_LINE_WORDS = 16;
  localparam int WORD_BITS        = 32;
  localparam int LINE_BITS        = CACHE_LINE_WORDS * WORD_BITS;
  localparam int IDX_BITS         = 4;
  localparam int CNT_BITS         = 5;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // Response type a beat must carry for a transfer of the given direction.
  function automatic logic [2:0] resp_type_for(input logic rw);
    return rw ? MEM_TYPE_WRITE : MEM_TYPE_READ;
  endfunction

endpackage

// File: rtl/lab3_cache_cache_mem_receiver_if.sv
// Command, memory-response and assembled-line handshakes of the line receiver.
interface lab3_cache_cache_mem_receiver_if;
  import lab3_cache_mem_pkg::*;

  logic                 cmd_val;
  logic                 cmd_rdy;
  logic [31:0]          cmd_addr;
  logic                 cmd_rw;
  logic                 mem_resp_val;
  logic                 mem_resp_rdy;
  mem_resp_4B_t         mem_resp;
  logic                 line_val;
  logic                 line_rdy;
  logic [LINE_BITS-1:0] line_data;
  logic                 line_rw;
  logic                 err;

  modport master (
    output cmd_val, cmd_addr, cmd_rw, mem_resp_val, mem_resp, line_rdy,
    input  cmd_rdy, mem_resp_rdy, line_val, line_data, line_rw, err
  );

  modport slave (
    input  cmd_val, cmd_addr, cmd_rw, mem_resp_val, mem_resp, line_rdy,
    output cmd_rdy, mem_resp_rdy, line_val, line_data, line_rw, err
  );

endinterface

// File: rtl/lab3_cache_cache_mem_receiver_ctrl.sv
// Receiver FSM (IDLE -> COLLECT -> DONE) and 16-beat counter; emits accept strobes for the datapath.
module lab3_cache_cache_mem_receiver_ctrl
  import lab3_cache_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic cmd_val,
  input  logic mem_resp_val,
  input  logic line_rdy,
  output logic cmd_rdy,
  output logic mem_resp_rdy,
  output logic line_val,
  output logic cmd_go,
  output logic beat_go
);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    cmd_rdy      = 1'b0;
    mem_resp_rdy = 1'b0;
    line_val     = 1'b0;
    cmd_go       = 1'b0;
    beat_go      = 1'b0;
    // Handshakes are suppressed while reset is high so nothing is accepted mid-abort.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          cmd_rdy = 1'b1;
          if (cmd_val) begin
            cmd_go  = 1'b1;
            count_d = '0;
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          mem_resp_rdy = 1'b1;
          if (mem_resp_val) begin
            beat_go = 1'b1;
            count_d = count_q + CNT_BITS'(1);
            if (count_q == CNT_BITS'(CACHE_LINE_WORDS - 1)) state_d = DONE;
          end
        end
        DONE: begin
          line_val = 1'b1;
          if (line_rdy) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lab3_cache_cache_mem_receiver.sv
// Line receiver: gathers 16 memory beats (wrapping from the start word) into one 512-bit line.
// Optional beat checking (type/len vs. transfer direction) enabled by CACHE_MEM_RECV_CHECK_EN.
module lab3_cache_cache_mem_receiver
  import lab3_cache_mem_pkg::*;
(
  input logic                           clk,
  input logic                           reset,
  lab3_cache_cache_mem_receiver_if.slave bus
);

  logic cmd_go, beat_go;
  logic cmd_rdy, mem_resp_rdy, line_val;

  lab3_cache_cache_mem_receiver_ctrl u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .cmd_val      (bus.cmd_val),
    .mem_resp_val (bus.mem_resp_val),
    .line_rdy     (bus.line_rdy),
    .cmd_rdy      (cmd_rdy),
    .mem_resp_rdy (mem_resp_rdy),
    .line_val     (line_val),
    .cmd_go       (cmd_go),
    .beat_go      (beat_go)
  );

  logic                                        rw_q, rw_d;
  logic [IDX_BITS-1:0]                         idx_q, idx_d;
  logic [CACHE_LINE_WORDS-1:0][WORD_BITS-1:0]  line_q, line_d;
  logic [CACHE_LINE_WORDS-1:0]                 word_we;

  // Write transfers never touch the line, so it stays at the zero loaded on command accept.
  for (genvar g = 0; g < CACHE_LINE_WORDS; g++) begin : g_word_we
    assign word_we[g] = beat_go & ~rw_q & (idx_q == IDX_BITS'(g));
  end

  always_comb begin
    rw_d   = rw_q;
    idx_d  = idx_q;
    line_d = line_q;
    if (cmd_go) begin
      rw_d   = bus.cmd_rw;
      idx_d  = bus.cmd_addr[5:2];
      line_d = '0;
    end else if (beat_go) begin
      idx_d  = idx_q + IDX_BITS'(1);
    end
    for (int w = 0; w < CACHE_LINE_WORDS; w++) begin
      if (word_we[w]) line_d[w] = bus.mem_resp.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q   <= 1'b0;
      idx_q  <= '0;
      line_q <= '0;
    end else begin
      rw_q   <= rw_d;
      idx_q  <= idx_d;
      line_q <= line_d;
    end
  end

  assign bus.cmd_rdy      = cmd_rdy;
  assign bus.mem_resp_rdy = mem_resp_rdy;
  assign bus.line_val     = line_val;
  assign bus.line_data    = line_q;
  assign bus.line_rw      = rw_q;

`ifdef CACHE_MEM_RECV_CHECK_EN
  logic err_q, err_d;
  logic beat_bad;

  assign beat_bad = (bus.mem_resp.typ != resp_type_for(rw_q)) || (bus.mem_resp.len != 2'd0);

  always_comb err_d = err_q | (beat_go & beat_bad);

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err = err_q;

  logic unused_in_bits;
  assign unused_in_bits = ^{bus.cmd_addr[31:6], bus.cmd_addr[1:0],
                            bus.mem_resp.opaque, bus.mem_resp.test};
`else
  assign bus.err = 1'b0;

  logic unused_in_bits;
  assign unused_in_bits = ^{bus.cmd_addr[31:6], bus.cmd_addr[1:0], bus.mem_resp.typ,
                            bus.mem_resp.opaque, bus.mem_resp.test, bus.mem_resp.len};
`endif

endmodule
